fetch_queue: RTL and testbench
==============================

# fetch_queue

Instruction prefetch queue sitting directly upstream of the CPU fetch stage. Runs a single-outstanding request/acknowledge fetch against a multi-cycle instruction memory and buffers up to DEPTH 16-bit instructions with their addresses. The fetch stage pops from the head, may stall popping, and redirects the stream on taken branches and jumps. The queue then discards all buffered and in-flight instructions.

## Interface
- DEPTH, 4: queue entries; power of two, 2..16.
- RESET_VECTOR, 16'h0000: first fetch address after reset.

- clock  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- redirect  in  1  taken branch/jump; flush queue and restart fetch.
- redirect_addr  in  16  new fetch address; bit 0 forced to 0.
- pop  in  1  consumer takes the head entry this cycle; ignored when instr_valid=0.
- instr_valid  out  1  head entry present.
- instr  out  16  head instruction.
- instr_pc  out  16  address of head instruction.
- next_pc  out  16  instr_pc + 2, modulo 2^16.
- mem_req  out  1  fetch request, registered.
- mem_addr  out  16  fetch address; stable while mem_req=1.
- mem_ack  in  1  single-cycle acknowledge; mem_rdata valid in the same cycle.
- mem_rdata  in  16  fetched instruction.

## Operation
- State: fetch_addr, count (0..DEPTH), head and tail pointers, and FSM {IDLE, REQ, DISCARD}.
- Reset values:
  - fetch_addr=RESET_VECTOR; count=0; FSM=IDLE.
  - mem_req=0, mem_addr=RESET_VECTOR.
  - instr_valid=0, instr=0, instr_pc=0, next_pc=16'h0002.
- Slot reservation: a request is issued only if count_next + 1 ≤ DEPTH, where count_next already includes this cycle's pop. An acknowledged word therefore always has a slot and overflow is impossible.
- IDLE:
  - redirect: load fetch_addr=redirect_addr & ~1, clear the queue, stay IDLE.
  - else if a slot is free: go to REQ with mem_addr=fetch_addr.
- REQ:
  - mem_req=1 holding mem_addr.
  - On mem_ack without redirect:
    - push {mem_rdata, mem_addr}; fetch_addr += 2 (wraps FFFE→0000).
    - If a further slot is free, stay in REQ with mem_addr = new fetch_addr (back-to-back, one fetch per cycle at zero-wait memory); else go to IDLE.
  - On mem_ack with redirect: drop the data, clear the queue, load the redirect address, go to IDLE.
  - redirect without mem_ack: clear the queue, load the redirect address, go to DISCARD.
- DISCARD:
  - mem_req stays 1 with the old address; a request is never withdrawn.
  - On mem_ack: drop the data, go to IDLE.
  - A further redirect in DISCARD only overwrites fetch_addr.
- pop with instr_valid=1: advance head; count decrements unless a push occurs the same cycle.
- Redirect has priority over pop and push. A pop in the redirect cycle is irrelevant because the queue empties.

## Timing
- mem_ack to instr_valid: 1 cycle (0 with bypass; see Configuration).
- First mem_req: on the first clock edge after reset deasserts.
- Redirect to queue empty: next edge. Redirect to new mem_req: 1 cycle from IDLE, or 1 cycle after the pending ack when in DISCARD.
- Full queue (count=DEPTH, no pop): no new request. A pop re-enables requests in that same cycle.
- Reset mid-request: mem_req drops asynchronously and the outstanding ack is not tracked. The memory must also be reset.

## Configuration
- FETCH_QUEUE_BYPASS_EN defined:
  - When the queue is empty and mem_ack=1 with no redirect, mem_rdata/mem_addr drive instr/instr_pc combinationally and instr_valid=1 in the same cycle.
  - If pop=1 the word is consumed and not stored; otherwise it is stored normally.
- Undefined: outputs come only from queue registers; ack-to-valid is 1 cycle.

## Structure
- Shared package cpu_fetch_pkg:
  - INSTR_W=16, ADDR_W=16, PC_STEP=2.
  - FSM state enum fetch_state_t {IDLE, REQ, DISCARD}.
- One sub-module fetch_fifo:
  - DEPTH×32 storage {instr, pc}, head/tail/count, synchronous flush.
  - No overflow protection; the parent guarantees it.
- FSM, address generation, slot reservation and bypass live in fetch_queue.

## Test plan
- Reset, zero-wait memory (ack the cycle after each req), pop every cycle → mem_addr 0000,0002,0004…; instr_pc follows 1 cycle behind ack; steady throughput 1 instr/cycle.
- pop held 0, ack every request → exactly 4 pushes (DEPTH=4); mem_req=0 while full; one pop → mem_req reasserts the same edge it is registered.
- Redirect to 16'h0041 while in REQ with ack delayed 3 cycles → mem_req held at old address, late data dropped, next mem_addr=0040, instr_valid=0 until the 0040 data arrives.
- Redirect and mem_ack in the same cycle → ack data never appears on instr; next request goes to the redirect address.
- fetch_addr reaches FFFE → next mem_addr=0000; next_pc for head FFFE is 0000.
- Assert reset while in REQ with 2 entries queued → mem_req=0, instr_valid=0 immediately; after release the first mem_addr=RESET_VECTOR.
- With FETCH_QUEUE_BYPASS_EN, empty queue, ack data 16'hA123 plus pop → instr=A123, instr_valid=1 that cycle, count remains 0.

Source files
------------

// File: rtl/cpu_fetch_pkg.sv
// Shared types and constants for the instruction fetch path.
// The 16-bit word and address widths and the fetch FSM encoding live here.
package cpu_fetch_pkg;

   localparam int unsigned INSTR_W = 16;
   localparam int unsigned ADDR_W  = 16;
   localparam int unsigned PC_STEP = 2;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      DISCARD
   } fetch_state_t;

   // Sequential instruction address; wraps modulo 2^ADDR_W.
   function automatic logic [ADDR_W-1:0] pc_next(input logic [ADDR_W-1:0] pc);
      return pc + ADDR_W'(PC_STEP);
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Circular buffer of {instr, pc} entries with head/tail/count and synchronous flush.
// The parent guarantees it never pushes into a full buffer.
module fetch_fifo
   import cpu_fetch_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   localparam int unsigned PTR_W = $clog2(DEPTH),
   localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               flush,
   input  logic               push,
   input  logic [INSTR_W-1:0] push_instr,
   input  logic [ADDR_W-1:0]  push_pc,
   input  logic               pop,
   output logic [INSTR_W-1:0] head_instr,
   output logic [ADDR_W-1:0]  head_pc,
   output logic [CNT_W-1:0]   count
);

   logic [INSTR_W+ADDR_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]          head_q, head_d;
   logic [PTR_W-1:0]          tail_q, tail_d;
   logic [CNT_W-1:0]          count_q, count_d;

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         if (push) tail_d = tail_q + 1'b1;
         if (pop)  head_d = head_q + 1'b1;
         unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Payload storage needs no reset; count gates its visibility.
   always_ff @(posedge clock) begin
      if (push && !flush) mem_q[tail_q] <= {push_instr, push_pc};
   end

   assign head_instr = mem_q[head_q][INSTR_W+ADDR_W-1:ADDR_W];
   assign head_pc    = mem_q[head_q][ADDR_W-1:0];
   assign count      = count_q;

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: single-outstanding fetch FSM, slot reservation and redirect flush.
// Define FETCH_QUEUE_BYPASS_EN to forward an acked word straight to the outputs when empty.
module fetch_queue
   import cpu_fetch_pkg::*;
#(
   parameter int unsigned       DEPTH        = 4,
   parameter logic [ADDR_W-1:0] RESET_VECTOR = 16'h0000
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               redirect,
   input  logic [ADDR_W-1:0]  redirect_addr,
   input  logic               pop,
   output logic               instr_valid,
   output logic [INSTR_W-1:0] instr,
   output logic [ADDR_W-1:0]  instr_pc,
   output logic [ADDR_W-1:0]  next_pc,
   output logic               mem_req,
   output logic [ADDR_W-1:0]  mem_addr,
   input  logic               mem_ack,
   input  logic [INSTR_W-1:0] mem_rdata
);

   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   fetch_state_t       state_q, state_d;
   logic [ADDR_W-1:0]  fetch_addr_q, fetch_addr_d;
   logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
   logic [ADDR_W-1:0]  fetch_addr_inc, redirect_even;
   logic [CNT_W-1:0]   count;
   logic [CNT_W:0]     count_after;
   logic [INSTR_W-1:0] head_instr;
   logic [ADDR_W-1:0]  head_pc;
   logic               q_valid, q_pop, ack_take, bypass, push, slot_free;

   assign q_valid        = (count != '0);
   assign q_pop          = pop & q_valid;
   assign ack_take       = (state_q == REQ) & mem_ack & ~redirect;
   assign fetch_addr_inc = pc_next(fetch_addr_q);
   assign redirect_even  = redirect_addr & ~ADDR_W'(1);

`ifdef FETCH_QUEUE_BYPASS_EN
   assign bypass = ack_take & ~q_valid;
`else
   assign bypass = 1'b0;
`endif

   // A bypassed word that is popped in the same cycle never occupies a slot.
   assign push        = ack_take & ~(bypass & pop);
   assign count_after = {1'b0, count} + (CNT_W + 1)'(push) - (CNT_W + 1)'(q_pop);
   assign slot_free   = count_after < (CNT_W + 1)'(DEPTH);

   always_comb begin
      state_d      = state_q;
      fetch_addr_d = fetch_addr_q;
      mem_addr_d   = mem_addr_q;
      unique case (state_q)
         IDLE: begin
            if (redirect) begin
               fetch_addr_d = redirect_even;
            end else if (slot_free) begin
               state_d    = REQ;
               mem_addr_d = fetch_addr_q;
            end
         end
         REQ: begin
            if (redirect) begin
               fetch_addr_d = redirect_even;
               state_d      = mem_ack ? IDLE : DISCARD;
            end else if (mem_ack) begin
               fetch_addr_d = fetch_addr_inc;
               if (slot_free) mem_addr_d = fetch_addr_inc;
               else           state_d    = IDLE;
            end
         end
         DISCARD: begin
            // The stale request stays up until acked; its data is dropped.
            if (redirect) fetch_addr_d = redirect_even;
            if (mem_ack)  state_d      = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         fetch_addr_q <= RESET_VECTOR;
         mem_addr_q   <= RESET_VECTOR;
      end else begin
         state_q      <= state_d;
         fetch_addr_q <= fetch_addr_d;
         mem_addr_q   <= mem_addr_d;
      end
   end

   fetch_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clock      (clock),
      .reset      (reset),
      .flush      (redirect),
      .push       (push),
      .push_instr (mem_rdata),
      .push_pc    (mem_addr_q),
      .pop        (q_pop),
      .head_instr (head_instr),
      .head_pc    (head_pc),
      .count      (count)
   );

   assign mem_req     = (state_q != IDLE);
   assign mem_addr    = mem_addr_q;
   assign instr_valid = q_valid | bypass;
   assign instr       = q_valid ? head_instr : (bypass ? mem_rdata  : '0);
   assign instr_pc    = q_valid ? head_pc    : (bypass ? mem_addr_q : '0);
   assign next_pc     = pc_next(instr_pc);

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue (DEPTH=4, RESET_VECTOR=0000).
// Covers streaming, full-queue stall, redirect handling, address wrap and reset mid-request.
module tb_fetch_queue;

   logic        clock;
   logic        reset;
   logic        redirect;
   logic [15:0] redirect_addr;
   logic        pop;
   logic        instr_valid;
   logic [15:0] instr;
   logic [15:0] instr_pc;
   logic [15:0] next_pc;
   logic        mem_req;
   logic [15:0] mem_addr;
   logic        mem_ack;
   logic [15:0] mem_rdata;

   int total = 0;
   int bad   = 0;

   fetch_queue #(
      .DEPTH        (4),
      .RESET_VECTOR (16'h0000)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .redirect      (redirect),
      .redirect_addr (redirect_addr),
      .pop           (pop),
      .instr_valid   (instr_valid),
      .instr         (instr),
      .instr_pc      (instr_pc),
      .next_pc       (next_pc),
      .mem_req       (mem_req),
      .mem_addr      (mem_addr),
      .mem_ack       (mem_ack),
      .mem_rdata     (mem_rdata)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Instruction word the memory returns for a given address.
   function automatic logic [15:0] word_at(input logic [15:0] a);
      return a ^ 16'hC3A5;
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      #2;
      reset = 1'b0;
   endtask

   initial begin
      redirect      = 1'b0;
      redirect_addr = 16'h0000;
      pop           = 1'b0;
      mem_ack       = 1'b0;
      mem_rdata     = 16'h0000;
      reset         = 1'b1;
      tick();

      // Reset state
      chk("rst_valid", instr_valid, 1'b0);
      chk("rst_instr", instr, 16'h0000);
      chk("rst_pc", instr_pc, 16'h0000);
      chk("rst_next_pc", next_pc, 16'h0002);
      chk("rst_req", mem_req, 1'b0);
      chk("rst_addr", mem_addr, 16'h0000);
      reset = 1'b0;

      // Zero-wait memory, pop every cycle
      tick();
      chk("s_req0", mem_req, 1'b1);
      chk("s_addr0", mem_addr, 16'h0000);
      chk("s_valid0", instr_valid, 1'b0);
      mem_ack   = 1'b1;
      mem_rdata = word_at(16'h0000);
      pop       = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("s_valid", instr_valid, 1'b1);
         chk("s_pc", instr_pc, 16'(2 * i));
         chk("s_instr", instr, word_at(16'(2 * i)));
         chk("s_addr", mem_addr, 16'(2 * i + 2));
         mem_rdata = word_at(16'(2 * i + 2));
      end
      mem_ack = 1'b0;
      pop     = 1'b0;
      pulse_reset();

      // Fill to DEPTH with no pops
      tick();
      chk("f_req0", mem_req, 1'b1);
      mem_ack   = 1'b1;
      mem_rdata = word_at(16'h0000);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("f_req", mem_req, (i < 3) ? 1'b1 : 1'b0);
         if (i < 3) mem_rdata = word_at(16'(2 * i + 2));
         else       mem_ack   = 1'b0;
      end
      tick();
      tick();
      chk("f_full_req", mem_req, 1'b0);
      chk("f_full_valid", instr_valid, 1'b1);
      chk("f_full_pc", instr_pc, 16'h0000);
      chk("f_full_instr", instr, word_at(16'h0000));
      pop = 1'b1;
      tick();
      pop = 1'b0;
      chk("f_pop_req", mem_req, 1'b1);
      chk("f_pop_addr", mem_addr, 16'h0008);
      chk("f_pop_pc", instr_pc, 16'h0002);

      // Redirect while REQ, ack arrives 3 cycles later
      redirect      = 1'b1;
      redirect_addr = 16'h0041;
      tick();
      redirect = 1'b0;
      chk("d_req1", mem_req, 1'b1);
      chk("d_addr1", mem_addr, 16'h0008);
      chk("d_valid1", instr_valid, 1'b0);
      tick();
      tick();
      chk("d_req3", mem_req, 1'b1);
      chk("d_addr3", mem_addr, 16'h0008);
      mem_ack   = 1'b1;
      mem_rdata = 16'hDEAD;
      tick();
      mem_ack = 1'b0;
      chk("d_ack_req", mem_req, 1'b0);
      chk("d_ack_valid", instr_valid, 1'b0);
      tick();
      chk("d_new_req", mem_req, 1'b1);
      chk("d_new_addr", mem_addr, 16'h0040);
      chk("d_new_valid", instr_valid, 1'b0);
      mem_ack   = 1'b1;
      mem_rdata = word_at(16'h0040);
      tick();
      mem_ack = 1'b0;
      chk("d_data_valid", instr_valid, 1'b1);
      chk("d_data_instr", instr, word_at(16'h0040));
      chk("d_data_pc", instr_pc, 16'h0040);
      chk("d_next_addr", mem_addr, 16'h0042);

      // Redirect and ack in the same cycle
      redirect      = 1'b1;
      redirect_addr = 16'h1234;
      mem_ack       = 1'b1;
      mem_rdata     = 16'hBEEF;
      tick();
      redirect = 1'b0;
      mem_ack  = 1'b0;
      chk("r_req", mem_req, 1'b0);
      chk("r_valid", instr_valid, 1'b0);
      tick();
      chk("r_new_req", mem_req, 1'b1);
      chk("r_new_addr", mem_addr, 16'h1234);
      chk("r_new_valid", instr_valid, 1'b0);
      mem_ack   = 1'b1;
      mem_rdata = word_at(16'h1234);
      tick();
      mem_ack = 1'b0;
      chk("r_data_instr", instr, word_at(16'h1234));
      chk("r_data_pc", instr_pc, 16'h1234);

      // Address wrap at FFFE
      redirect      = 1'b1;
      redirect_addr = 16'hFFFD;
      tick();
      redirect  = 1'b0;
      mem_ack   = 1'b1;
      mem_rdata = 16'h5555;
      tick();
      mem_ack = 1'b0;
      tick();
      chk("w_addr_fffc", mem_addr, 16'hFFFC);
      mem_ack   = 1'b1;
      mem_rdata = word_at(16'hFFFC);
      tick();
      chk("w_pc_fffc", instr_pc, 16'hFFFC);
      chk("w_next_fffc", next_pc, 16'hFFFE);
      chk("w_addr_fffe", mem_addr, 16'hFFFE);
      pop       = 1'b1;
      mem_rdata = word_at(16'hFFFE);
      tick();
      pop = 1'b0;
      chk("w_addr_0000", mem_addr, 16'h0000);
      chk("w_pc_fffe", instr_pc, 16'hFFFE);
      chk("w_next_0000", next_pc, 16'h0000);
      chk("w_instr_fffe", instr, word_at(16'hFFFE));
      mem_rdata = word_at(16'h0000);
      tick();
      mem_ack = 1'b0;
      chk("w_two_req", mem_req, 1'b1);
      chk("w_two_addr", mem_addr, 16'h0002);

      // Reset while REQ with 2 entries queued
      reset = 1'b1;
      #1;
      chk("m_rst_req", mem_req, 1'b0);
      chk("m_rst_valid", instr_valid, 1'b0);
      chk("m_rst_addr", mem_addr, 16'h0000);
      chk("m_rst_next_pc", next_pc, 16'h0002);
      #1;
      reset = 1'b0;
      tick();
      chk("m_rel_req", mem_req, 1'b1);
      chk("m_rel_addr", mem_addr, 16'h0000);

      // Empty queue, ack plus pop
      mem_ack   = 1'b1;
      mem_rdata = 16'hA123;
      pop       = 1'b1;
      #1;
`ifdef FETCH_QUEUE_BYPASS_EN
      chk("b_valid", instr_valid, 1'b1);
      chk("b_instr", instr, 16'hA123);
      chk("b_pc", instr_pc, 16'h0000);
`else
      chk("b_valid", instr_valid, 1'b0);
      chk("b_instr", instr, 16'h0000);
`endif
      tick();
      mem_ack = 1'b0;
      pop     = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
      chk("b_after_valid", instr_valid, 1'b0);
`else
      chk("b_after_valid", instr_valid, 1'b1);
      chk("b_after_instr", instr, 16'hA123);
`endif
      chk("b_after_addr", mem_addr, 16'h0002);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
